// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and default widths for the Risco-5 memory path (core, arbiter, SPI controller).
// Holds no logic; widths here are the defaults the top-level instances agree on.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] FETCH_WSTRB = 4'hF;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Loadable up-counter with clear/enable and a terminal-count flag; TC_VAL of 0 never flags.
// Single-cycle update, no handshake: clear beats load, load beats enable.
module arb_timeout_counter #(
  parameter int W      = 8,
  parameter int TC_VAL = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (TC_VAL != 0) && (count_q == W'(TC_VAL));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter for the single SPI memory port with data-streak fairness and timeout.
// req->m_req 1 cycle, m_ack->x_ack 1 cycle; requests are held off (not sampled) until the arbiter is IDLE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int STK_W = cnt_width(MAX_D_STREAK);
  localparam int TMR_W = cnt_width(TIMEOUT_CYC);

  arb_state_e        state_q, state_d;
  logic [STK_W-1:0]  d_streak_q, d_streak_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic              i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic   grant;
  owner_e grant_own;
  logic   timer_clr;
  logic   timer_tc;
  logic   in_grant;

  assign in_grant = (state_q == ARB_GRANT_I) || (state_q == ARB_GRANT_D);

  // Loaded with 1 on grant so the count equals the number of GRANT cycles seen.
  arb_timeout_counter #(
    .W      (TMR_W),
    .TC_VAL (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .load     (grant),
    .load_val (TMR_W'(1)),
    .en       (in_grant),
    .tc       (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    d_streak_d = d_streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    i_err_d    = 1'b0;
    d_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant      = 1'b0;
    grant_own  = OWN_I;
    timer_clr  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (d_req && (!i_req || (d_streak_q < STK_W'(MAX_D_STREAK)))) begin
          grant     = 1'b1;
          grant_own = OWN_D;
        end else if (i_req) begin
          grant     = 1'b1;
          grant_own = OWN_I;
        end
        if (grant) begin
          m_req_d = 1'b1;
          if (grant_own == OWN_D) begin
            state_d   = ARB_GRANT_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            // Data only wins over a pending fetch below the cap, so this never overflows.
            d_streak_d = i_req ? d_streak_q + 1'b1 : '0;
          end else begin
            state_d    = ARB_GRANT_I;
            m_we_d     = 1'b0;
            m_addr_d   = i_addr;
            m_wdata_d  = '0;
            m_wstrb_d  = FETCH_WSTRB;
            d_streak_d = '0;
          end
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        if (m_ack) begin
          m_req_d   = 1'b0;
          timer_clr = 1'b1;
          state_d   = ARB_RESP;
          if (state_q == ARB_GRANT_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = m_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end
        end else if (timer_tc) begin
          m_req_d   = 1'b0;
          timer_clr = 1'b1;
          state_d   = ARB_RESP;
          if (state_q == ARB_GRANT_D) begin
            d_err_d = 1'b1;
          end else begin
            i_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      d_streak_q <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_err_q    <= i_err_d;
      d_err_q    <= d_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_err   = i_err_q;
  assign d_err   = d_err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requesters and memory model drive at posedge+1,
// the control sequence at posedge+3, and the monitor checks at negedge.
module tb_mem_bus_arbiter;

  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int MAXS = 3;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack, i_err;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          busy;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Stimulus controls, written only by the main sequence.
  int            f_goal = 0, d_goal = 0, gap_max = 0;
  bit            f_fix = 0, d_fix = 0;
  logic [AW-1:0] f_fix_addr = '0, d_fix_addr = '0;
  logic [DW-1:0] d_fix_wdata = '0;
  logic [3:0]    d_fix_wstrb = '0;
  bit            d_fix_we = 0;
  bit            force_on = 0, force_hang = 0, stray_en = 0, stray_once = 0;
  int            force_dly = 0;
  logic [DW-1:0] force_data = '0;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] data;
    int            len;
  } exp_t;
  exp_t exp_q[$];
  bit   glog[$];   // 1 = data grant, 0 = fetch grant
  int   n_i_ack = 0, n_d_ack = 0, n_i_err = 0, n_d_err = 0;

  // Fetch requester.
  int f_issued = 0, f_gap = 0;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      i_req = 1'b0;
    end else if (i_req) begin
      if (i_ack || i_err) i_req = 1'b0;
    end else if (f_issued < f_goal) begin
      if (f_gap > 0) begin
        f_gap--;
      end else begin
        i_req  = 1'b1;
        i_addr = f_fix ? f_fix_addr : AW'($urandom);
        f_issued++;
        f_gap = $urandom_range(gap_max, 0);
      end
    end
  end

  // Data requester.
  int d_issued = 0, d_gap = 0;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      d_req = 1'b0;
    end else if (d_req) begin
      if (d_ack || d_err) d_req = 1'b0;
    end else if (d_issued < d_goal) begin
      if (d_gap > 0) begin
        d_gap--;
      end else begin
        d_req   = 1'b1;
        d_we    = d_fix ? d_fix_we : 1'($urandom);
        d_addr  = d_fix ? d_fix_addr : AW'($urandom);
        d_wdata = d_fix ? d_fix_wdata : $urandom;
        d_wstrb = d_fix ? d_fix_wstrb : 4'($urandom);
        d_issued++;
        d_gap = $urandom_range(gap_max, 0);
      end
    end
  end

  // Memory controller model: picks an ack delay (or a hang) per transaction and
  // pushes the response the arbiter owes its requester.
  bit r_active = 0, r_hang = 0;
  int r_cnt = 0, r_dly = 0;
  always begin
    @(posedge clk);
    #1;
    m_ack   = 1'b0;
    m_rdata = $urandom;
    if (rst) begin
      r_active = 0;
    end else if (m_req) begin
      if (!r_active) begin
        r_active = 1;
        r_cnt    = 0;
        if (force_on) begin
          r_hang = force_hang;
          r_dly  = force_dly;
        end else begin
          r_hang = ($urandom_range(7, 0) == 0);
          r_dly  = $urandom_range(TMO - 1, 0);
        end
        if (r_hang) exp_q.push_back('{1'b1, 32'd0, TMO});
      end
      if (!r_hang && r_cnt == r_dly) begin
        m_ack = 1'b1;
        if (force_on) m_rdata = force_data;
        exp_q.push_back('{1'b0, m_rdata, r_dly + 1});
        r_active = 0;
      end
      r_cnt++;
    end else begin
      if (r_active && r_hang) m_ack = 1'b1;   // late ack after a timeout
      r_active = 0;
      if (stray_once || (stray_en && $urandom_range(9, 0) == 0)) m_ack = 1'b1;
      stray_once = 0;
    end
  end

  // Monitor: arbitration reference plus response scoreboard.
  bit            prev_m_req = 0, prev_busy = 0, prev_i_req = 0, prev_d_req = 0, prev_d_we = 0;
  logic [AW-1:0] prev_i_addr = '0, prev_d_addr = '0;
  logic [DW-1:0] prev_d_wdata = '0;
  logic [3:0]    prev_d_wstrb = '0;
  bit            cur_d = 0, after_resp = 0, exp_d;
  int            streak = 0, mreq_len = 0;
  logic [DW-1:0] last_i = '0, last_d = '0;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      prev_m_req = 0; prev_busy = 0; prev_i_req = 0; prev_d_req = 0;
      streak = 0; mreq_len = 0; after_resp = 0;
      last_i = '0; last_d = '0;
      exp_q.delete();
    end else begin
      if (m_req && !prev_m_req) begin
        check("grant_from_idle", prev_busy, 1'b0);
        check("grant_has_request", prev_i_req || prev_d_req, 1'b1);
        exp_d = prev_d_req && (!prev_i_req || streak < MAXS);
        if (exp_d) begin
          check("d_grant_we", m_we, prev_d_we);
          check("d_grant_addr", m_addr, prev_d_addr);
          check("d_grant_wdata", m_wdata, prev_d_wdata);
          check("d_grant_wstrb", m_wstrb, prev_d_wstrb);
          streak = prev_i_req ? streak + 1 : 0;
        end else begin
          check("i_grant_we", m_we, 1'b0);
          check("i_grant_addr", m_addr, prev_i_addr);
          check("i_grant_wstrb", m_wstrb, 4'hF);
          streak = 0;
        end
        cur_d = exp_d;
        glog.push_back(exp_d);
        mreq_len = 0;
      end else if (!prev_busy && (prev_i_req || prev_d_req)) begin
        check("grant_latency", m_req, 1'b1);
      end
      if (m_req) begin
        mreq_len++;
        check("busy_with_m_req", busy, 1'b1);
      end
      if (i_ack || d_ack || i_err || d_err) begin
        check("one_pulse", int'(i_ack) + int'(d_ack) + int'(i_err) + int'(d_err), 1);
        n_i_ack += int'(i_ack); n_d_ack += int'(d_ack);
        n_i_err += int'(i_err); n_d_err += int'(d_err);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_response actual=i_ack%0b/d_ack%0b/i_err%0b/d_err%0b required=none",
                   i_ack, d_ack, i_err, d_err);
        end else begin
          e = exp_q.pop_front();
          check("m_req_cycles", mreq_len, e.len);
          check("i_ack", i_ack, !e.is_err && !cur_d);
          check("d_ack", d_ack, !e.is_err && cur_d);
          check("i_err", i_err, e.is_err && !cur_d);
          check("d_err", d_err, e.is_err && cur_d);
          if (!e.is_err) begin
            if (cur_d) last_d = e.data;
            else       last_i = e.data;
          end
        end
        after_resp = 1;
      end else if (after_resp) begin
        check("busy_after_resp", busy, 1'b0);
        after_resp = 0;
      end
      check("i_rdata", i_rdata, last_i);
      check("d_rdata", d_rdata, last_d);
      prev_m_req = m_req;   prev_busy = busy;
      prev_i_req = i_req;   prev_d_req = d_req;
      prev_i_addr = i_addr; prev_d_addr = d_addr;
      prev_d_we = d_we;     prev_d_wdata = d_wdata; prev_d_wstrb = d_wstrb;
    end
  end

  task automatic sync();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      sync();
      n++;
    end while (!(f_issued == f_goal && d_issued == d_goal && !i_req && !d_req && !busy)
               && n < budget);
    check({name, "_completes"}, n < budget, 1'b1);
  endtask

  int  base, n, sa, sd;
  bit  fair_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_req", m_req, 1'b0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_addr", m_addr, 24'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_m_wstrb", m_wstrb, 4'h0);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_i_err", i_err, 1'b0);
    check("rst_d_err", d_err, 1'b0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    sync();
    rst = 1'b0;

    // Single fetch, ack 3 cycles after m_req rises.
    force_on = 1; force_hang = 0; force_dly = 3; force_data = 32'h00000013;
    f_fix = 1; f_fix_addr = 24'h000100;
    base = glog.size();
    f_goal++;
    wait_idle("single_fetch", 50);
    check("single_fetch_grants", glog.size() - base, 1);
    if (glog.size() > base) check("single_fetch_owner", glog[base], 1'b0);
    check("single_fetch_rdata", i_rdata, 32'h00000013);
    check("single_fetch_m_addr", m_addr, 24'h000100);
    check("single_fetch_m_we", m_we, 1'b0);
    check("single_fetch_m_wstrb", m_wstrb, 4'hF);

    // Simultaneous requests: data first, fetch straight after RESP.
    force_dly = 1; force_data = 32'hCAFE0001;
    f_fix_addr = 24'h000300;
    d_fix = 1; d_fix_we = 1; d_fix_addr = 24'h000200; d_fix_wdata = 32'hDEADBEEF; d_fix_wstrb = 4'b0011;
    base = glog.size();
    f_goal++; d_goal++;
    wait_idle("simultaneous", 60);
    check("simul_grants", glog.size() - base, 2);
    if (glog.size() >= base + 2) begin
      check("simul_first_d", glog[base], 1'b1);
      check("simul_second_i", glog[base+1], 1'b0);
    end
    check("simul_d_rdata", d_rdata, 32'hCAFE0001);

    // Timeout on a data access; the late ack must be ignored.
    sa = n_d_ack; sd = n_d_err;
    force_hang = 1;
    d_goal++;
    wait_idle("timeout", 60);
    check("timeout_d_err_count", n_d_err - sd, 1);
    check("timeout_no_d_ack", n_d_ack - sa, 0);
    check("timeout_d_rdata_held", d_rdata, 32'hCAFE0001);

    // Stray ack while idle.
    sa = n_i_ack + n_d_ack;
    stray_once = 1;
    repeat (4) sync();
    check("stray_no_ack", n_i_ack + n_d_ack - sa, 0);
    check("stray_busy", busy, 1'b0);
    check("stray_m_req", m_req, 1'b0);

    // Reset in the middle of a data transaction (streak already 1).
    force_hang = 1; f_fix = 0; d_fix = 0;
    f_goal++; d_goal++;
    n = 0;
    do begin sync(); n++; end while (!m_req && n < 20);
    check("rst_mid_reached_grant", m_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_m_req", m_req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (2) sync();
    rst = 1'b0;
    sync();
    check("rst_mid_idle", busy, 1'b0);

    // Fairness from a fresh streak: D D D I D I.
    force_hang = 0; force_dly = 0; gap_max = 0;
    base = glog.size();
    f_goal += 2; d_goal += 4;
    wait_idle("fairness", 120);
    check("fair_grants", glog.size() - base, 6);
    for (int k = 0; k < 6; k++) begin
      if (glog.size() > base + k) check($sformatf("fair_order_%0d", k), glog[base+k], fair_exp[k]);
    end

    // Randomised traffic with random delays, hangs and stray acks.
    force_on = 0; stray_en = 1; gap_max = 3;
    f_goal += 40; d_goal += 40;
    wait_idle("random", 8000);
    stray_en = 0;
    repeat (3) sync();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
